multicycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 8-bit CPU datapath (16-bit instruction word, 4-bit opcode in bits [15:12], 3-bit ALU select, 8-bit PC).
- Replaces the single-cycle, always-increment PC behaviour with an FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives PC increment/load, IR capture, register write and a request/acknowledge handshake to data memory; also provides halt, memory-timeout fault and a retired-instruction count.

---
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, with a memory handshake timeout and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int unsigned CntW       = 16,
  parameter int unsigned MemTimeout = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic [3:0]      opcode_i,
  input  logic            carry_i,
  input  logic            mem_ack_i,
  output logic            ir_load_o,
  output logic            pc_inc_o,
  output logic            pc_load_o,
  output logic [2:0]      alu_op_o,
  output logic            reg_write_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            halted_o,
  output logic            fault_o,
  output logic [CntW-1:0] instr_count_o,
  output logic [2:0]      state_dbg_o
);

  localparam int unsigned TmoW = (MemTimeout > 2) ? $clog2(MemTimeout) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MemTimeout - 1);

  localparam logic [3:0] OpLoad  = 4'b1000;
  localparam logic [3:0] OpStore = 4'b1001;
  localparam logic [3:0] OpJmp   = 4'b1010;
  localparam logic [3:0] OpBrc   = 4'b1011;
  localparam logic [3:0] OpHalt  = 4'b1111;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalted  = 3'd6,
    StFault   = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              retire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= 4'b0000;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (run_i) begin
          op_d    = opcode_i;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        if (!op_q[3]) begin
          state_d = StWb;
        end else if (op_q == OpLoad || op_q == OpStore) begin
          state_d = StMem;
          tmo_d   = '0;
        end else if (op_q == OpHalt) begin
          state_d = StHalted;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack_i) begin
          state_d = (op_q == OpStore) ? StFetch : StWb;
        end else if (MemTimeout != 0 && tmo_q == TmoLast) begin
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb:     state_d = StFetch;
      StHalted: state_d = StHalted;
      StFault:  state_d = StFault;
    endcase
  end

  // Retire on return to FETCH from an instruction body, or on entering HALTED.
  always_comb begin
    retire = 1'b0;
    if (state_d == StFetch &&
        (state_q == StExecute || state_q == StMem || state_q == StWb)) begin
      retire = 1'b1;
    end
    if (state_d == StHalted && state_q != StHalted) begin
      retire = 1'b1;
    end
    cnt_d = retire ? cnt_q + CntW'(1) : cnt_q;
  end

  always_comb begin
    ir_load_o   = 1'b0;
    pc_inc_o    = 1'b0;
    pc_load_o   = 1'b0;
    reg_write_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    halted_o    = 1'b0;
    fault_o     = 1'b0;
    alu_op_o    = (state_q != StIdle && !op_q[3]) ? op_q[2:0] : 3'b000;
    unique case (state_q)
      StFetch: begin
        ir_load_o = run_i;
        pc_inc_o  = run_i;
      end
      StExecute: begin
        if (op_q == OpJmp) begin
          pc_load_o = 1'b1;
        end else if (op_q == OpBrc) begin
          pc_load_o = carry_i;
        end
      end
      StMem: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op_q == OpStore);
      end
      StWb:     reg_write_o = 1'b1;
      StHalted: halted_o = 1'b1;
      StFault:  fault_o = 1'b1;
      default: ;
    endcase
  end

  assign instr_count_o = cnt_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: table of single-instruction vectors plus
// hand-written sequences for pause, timeout, halt, async reset and counter wrap.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        run_i;
  logic [3:0]  opcode_i;
  logic        carry_i;
  logic        mem_ack_i;

  logic        ir_load, pc_inc, pc_load, reg_write, mem_req, mem_we, halted, fault;
  logic [2:0]  alu_op, state_dbg;
  logic [15:0] instr_count;

  logic        ir_load_w, pc_inc_w, pc_load_w, reg_write_w, mem_req_w, mem_we_w;
  logic        halted_w, fault_w;
  logic [2:0]  alu_op_w, state_dbg_w;
  logic [1:0]  instr_count_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .opcode_i(opcode_i), .carry_i(carry_i),
    .mem_ack_i(mem_ack_i), .ir_load_o(ir_load), .pc_inc_o(pc_inc), .pc_load_o(pc_load),
    .alu_op_o(alu_op), .reg_write_o(reg_write), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .halted_o(halted), .fault_o(fault), .instr_count_o(instr_count), .state_dbg_o(state_dbg)
  );

  // Narrow counter, timeout disabled; shares all inputs with the main instance.
  multicycle_sequencer #(.CntW(2), .MemTimeout(0)) dut_w (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .opcode_i(opcode_i), .carry_i(carry_i),
    .mem_ack_i(mem_ack_i), .ir_load_o(ir_load_w), .pc_inc_o(pc_inc_w),
    .pc_load_o(pc_load_w), .alu_op_o(alu_op_w), .reg_write_o(reg_write_w),
    .mem_req_o(mem_req_w), .mem_we_o(mem_we_w), .halted_o(halted_w), .fault_o(fault_w),
    .instr_count_o(instr_count_w), .state_dbg_o(state_dbg_w)
  );

  typedef struct {
    logic [3:0] op;
    logic       carry;
    int         ack_dly;
    int         len;
    int         rw;
    int         pcl;
    int         req;
    int         we;
    logic [2:0] alu;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a negedge with the DUT in FETCH; runs until FETCH/HALTED/FAULT.
  task automatic run_instr(input logic [3:0] op, input logic carry, input int ack_dly,
                           output int len, output int rw, output int pcl, output int req,
                           output int we, output int irl, output int bad,
                           output logic [2:0] alu_e, output logic [2:0] end_st);
    int mem_seen;
    len = 0; rw = 0; pcl = 0; req = 0; we = 0; irl = 0; bad = 0; alu_e = 3'd0;
    mem_seen = 0;
    for (int c = 0; c < 60; c++) begin
      run_i     = 1'b1;
      opcode_i  = op;
      carry_i   = carry;
      mem_ack_i = (state_dbg == 3'd4 && ack_dly >= 0 && mem_seen == ack_dly);
      #1;
      if (ir_load) irl++;
      if (pc_load) pcl++;
      if (reg_write) rw++;
      if (mem_req) req++;
      if (mem_we) we++;
      if (state_dbg == 3'd3) alu_e = alu_op;
      if ((ir_load ^ pc_inc) || (pc_load && (ir_load || pc_inc || reg_write)) ||
          (reg_write && (ir_load || pc_inc))) bad++;
      if (state_dbg == 3'd4) mem_seen++;
      @(negedge clk);
      len++;
      if (state_dbg == 3'd1 || state_dbg == 3'd6 || state_dbg == 3'd7) break;
    end
    mem_ack_i = 1'b0;
    end_st    = state_dbg;
  endtask

  vec_t        vecs[12];
  int          len, rw, pcl, req, we, irl, bad;
  logic [2:0]  alu_e, end_st;
  logic [15:0] cnt0;

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, -1, 4, 1, 0, 0, 0, 3'd0};
    vecs[1]  = '{4'b0101, 1'b0, -1, 4, 1, 0, 0, 0, 3'd5};
    vecs[2]  = '{4'b0111, 1'b1, -1, 4, 1, 0, 0, 0, 3'd7};
    vecs[3]  = '{4'b1000, 1'b0,  0, 5, 1, 0, 1, 0, 3'd0};
    vecs[4]  = '{4'b1000, 1'b0,  3, 8, 1, 0, 4, 0, 3'd0};
    vecs[5]  = '{4'b1001, 1'b0,  0, 4, 0, 0, 1, 1, 3'd0};
    vecs[6]  = '{4'b1001, 1'b0,  2, 6, 0, 0, 3, 3, 3'd0};
    vecs[7]  = '{4'b1010, 1'b0, -1, 3, 0, 1, 0, 0, 3'd0};
    vecs[8]  = '{4'b1011, 1'b1, -1, 3, 0, 1, 0, 0, 3'd0};
    vecs[9]  = '{4'b1011, 1'b0, -1, 3, 0, 0, 0, 0, 3'd0};
    vecs[10] = '{4'b1100, 1'b1, -1, 3, 0, 0, 0, 0, 3'd0};
    vecs[11] = '{4'b1110, 1'b0, -1, 3, 0, 0, 0, 0, 3'd0};

    rst_ni = 1'b0; run_i = 1'b0; opcode_i = 4'b0000; carry_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    check("reset_strobes", {ir_load, pc_inc, pc_load, reg_write, mem_req, mem_we, halted,
                            fault}, 8'h00);
    check("reset_alu_op", alu_op, 3'd0);
    check("reset_state", state_dbg, 3'd0);
    check("reset_count", instr_count, 16'd0);

    run_i = 1'b1;
    rst_ni = 1'b1;
    #1 check("idle_after_release", state_dbg, 3'd0);
    check("idle_no_ir_load", ir_load, 1'b0);
    @(negedge clk);
    check("first_fetch_state", state_dbg, 3'd1);
    check("first_fetch_strobes", {ir_load, pc_inc}, 2'b11);

    for (int i = 0; i < 12; i++) begin
      cnt0 = instr_count;
      run_instr(vecs[i].op, vecs[i].carry, vecs[i].ack_dly, len, rw, pcl, req, we, irl, bad,
                alu_e, end_st);
      check($sformatf("v%0d_len", i), len, vecs[i].len);
      check($sformatf("v%0d_reg_write", i), rw, vecs[i].rw);
      check($sformatf("v%0d_pc_load", i), pcl, vecs[i].pcl);
      check($sformatf("v%0d_mem_req", i), req, vecs[i].req);
      check($sformatf("v%0d_mem_we", i), we, vecs[i].we);
      check($sformatf("v%0d_alu_op", i), alu_e, vecs[i].alu);
      check($sformatf("v%0d_ir_load", i), irl, 1);
      check($sformatf("v%0d_strobe_overlap", i), bad, 0);
      check($sformatf("v%0d_end_state", i), end_st, 3'd1);
      check($sformatf("v%0d_count_delta", i), instr_count - cnt0, 16'd1);
    end
    check("count_after_table", instr_count, 16'd12);

    // Pause in FETCH, then resume on the first cycle run is high.
    for (int i = 0; i < 5; i++) begin
      run_i = 1'b0;
      #1;
      check($sformatf("pause%0d_strobes", i), {ir_load, pc_inc, pc_load, reg_write, mem_req},
            5'b0);
      check($sformatf("pause%0d_state", i), state_dbg, 3'd1);
      @(negedge clk);
    end
    run_i = 1'b1;
    #1 check("resume_ir_load", {ir_load, pc_inc}, 2'b11);

    // Async reset while a LOAD is waiting in MEM.
    opcode_i = 4'b1000;
    mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("midmem_state", state_dbg, 3'd4);
    check("midmem_req", {mem_req, mem_we}, 2'b10);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_strobes", {ir_load, pc_inc, pc_load, reg_write, mem_req, mem_we},
          6'b0);
    check("async_reset_state", state_dbg, 3'd0);
    check("async_reset_count", instr_count, 16'd0);
    @(posedge clk);
    #1 check("reset_held_no_req", mem_req, 1'b0);

    // Narrow counter wraps after four retirements.
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      run_instr(4'b1100, 1'b0, -1, len, rw, pcl, req, we, irl, bad, alu_e, end_st);
    end
    check("wrap_count_narrow", instr_count_w, 2'd1);
    check("wrap_count_wide", instr_count, 16'd5);

    // STORE with no ack: main instance faults, the timeout-disabled one keeps waiting.
    cnt0 = instr_count;
    run_instr(4'b1001, 1'b0, -1, len, rw, pcl, req, we, irl, bad, alu_e, end_st);
    check("timeout_len", len, 18);
    check("timeout_mem_cycles", req, 15);
    check("timeout_store_we", we, 15);
    check("timeout_end_state", end_st, 3'd7);
    check("timeout_no_timeout_inst", {state_dbg_w, mem_req_w}, {3'd4, 1'b1});
    for (int i = 0; i < 3; i++) begin
      run_i = 1'b1;
      mem_ack_i = 1'b1;
      #1;
      check($sformatf("fault%0d_flags", i), {fault, halted, mem_req, ir_load}, 4'b1000);
      check($sformatf("fault%0d_state", i), state_dbg, 3'd7);
      check($sformatf("fault%0d_count", i), instr_count, cnt0);
      @(negedge clk);
    end
    mem_ack_i = 1'b0;

    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_instr(4'b1111, 1'b0, -1, len, rw, pcl, req, we, irl, bad, alu_e, end_st);
    check("halt_len", len, 3);
    check("halt_end_state", end_st, 3'd6);
    check("halt_count", instr_count, 16'd1);
    for (int i = 0; i < 3; i++) begin
      run_i = 1'b1;
      #1;
      check($sformatf("halted%0d_flags", i), {halted, fault, ir_load, pc_inc}, 4'b1000);
      check($sformatf("halted%0d_state", i), state_dbg, 3'd6);
      @(negedge clk);
    end
    check("halt_count_stable", instr_count, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
